// File: rtl/mib_queue.sv
// ============================================================================
//  Module   : mib_queue
//  Purpose  : Show-ahead FIFO of move / immediate instructions with a sticky
//             protocol-violation flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mib_queue #(
   parameter int DEPTH      = 4,
   parameter int PORT_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_move_valid,
   input  logic                       in_immediate_valid,
   input  logic [PORT_WIDTH-1:0]      in_src,
   input  logic [PORT_WIDTH-1:0]      in_dst,
   input  logic [DATA_WIDTH-1:0]      in_data,
   output logic                       in_ready,
   output logic                       out_move_valid,
   output logic                       out_immediate_valid,
   output logic [PORT_WIDTH-1:0]      out_src,
   output logic [PORT_WIDTH-1:0]      out_dst,
   output logic [DATA_WIDTH-1:0]      out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       error
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

   // Entry storage; type bit is 1 for an immediate, 0 for a move.
   logic                  r_type_mem [DEPTH];
   logic [PORT_WIDTH-1:0] r_src_mem  [DEPTH];
   logic [PORT_WIDTH-1:0] r_dst_mem  [DEPTH];
   logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];

   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               r_error;

   logic w_full;
   logic w_valid;
   logic w_push;
   logic w_pop;
   logic w_head_imm;
   logic w_conflict;

   // in_ready depends only on registered occupancy, never on out_ready.
   assign w_full     = (r_count == c_depth);
   assign w_valid    = (r_count != '0);
   assign w_conflict = in_move_valid & in_immediate_valid;
   assign w_push     = (in_move_valid ^ in_immediate_valid) & ~w_full;
   assign w_pop      = w_valid & out_ready;
   assign w_head_imm = r_type_mem[r_rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_error  <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
         if (w_push && !w_pop)      r_count <= r_count + c_cnt_one;
         else if (w_pop && !w_push) r_count <= r_count - c_cnt_one;
         if (w_conflict) r_error <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push && !reset) begin
         r_type_mem[r_wr_ptr] <= in_immediate_valid;
         r_src_mem[r_wr_ptr]  <= in_src;
         r_dst_mem[r_wr_ptr]  <= in_dst;
         r_data_mem[r_wr_ptr] <= in_data;
      end
   end

   // Unused fields of the head entry are forced to zero at the outputs.
   assign out_move_valid      = w_valid & ~w_head_imm;
   assign out_immediate_valid = w_valid &  w_head_imm;
   assign out_src  = (w_valid && !w_head_imm) ? r_src_mem[r_rd_ptr]  : '0;
   assign out_data = (w_valid &&  w_head_imm) ? r_data_mem[r_rd_ptr] : '0;
   assign out_dst  = w_valid ? r_dst_mem[r_rd_ptr] : '0;

   assign in_ready = ~w_full;
   assign count    = r_count;
   assign empty    = ~w_valid;
   assign error    = r_error;

endmodule

`default_nettype wire

// File: tb/tb_mib_queue.sv
// ============================================================================
//  Module   : tb_mib_queue
//  Purpose  : Directed and randomised scoreboard bench for mib_queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mib_queue;

   localparam int DEPTH      = 4;
   localparam int PORT_WIDTH = 8;
   localparam int DATA_WIDTH = 32;

   typedef struct packed {
      bit                    is_imm;
      logic [PORT_WIDTH-1:0] src;
      logic [PORT_WIDTH-1:0] dst;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  in_move_valid;
   logic                  in_immediate_valid;
   logic [PORT_WIDTH-1:0] in_src;
   logic [PORT_WIDTH-1:0] in_dst;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  out_move_valid;
   logic                  out_immediate_valid;
   logic [PORT_WIDTH-1:0] out_src;
   logic [PORT_WIDTH-1:0] out_dst;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   logic [$clog2(DEPTH):0] count;
   logic                  empty;
   logic                  error;

   entry_t sb[$];
   bit     m_err;
   int     vectors;
   int     miscompares;

   mib_queue #(
      .DEPTH      (DEPTH),
      .PORT_WIDTH (PORT_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .in_move_valid       (in_move_valid),
      .in_immediate_valid  (in_immediate_valid),
      .in_src              (in_src),
      .in_dst              (in_dst),
      .in_data             (in_data),
      .in_ready            (in_ready),
      .out_move_valid      (out_move_valid),
      .out_immediate_valid (out_immediate_valid),
      .out_src             (out_src),
      .out_dst             (out_dst),
      .out_data            (out_data),
      .out_ready           (out_ready),
      .count               (count),
      .empty               (empty),
      .error               (error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the scoreboard head and model state.
   task automatic check_state(input string tag);
      bit     has;
      entry_t h;
      has = (sb.size() != 0);
      h   = has ? sb[0] : '0;
      chk({tag, ".mv"},    64'(out_move_valid),      64'(has && !h.is_imm));
      chk({tag, ".iv"},    64'(out_immediate_valid), 64'(has &&  h.is_imm));
      chk({tag, ".src"},   64'(out_src),  (has && !h.is_imm) ? 64'(h.src)  : 64'd0);
      chk({tag, ".dst"},   64'(out_dst),  has ? 64'(h.dst) : 64'd0);
      chk({tag, ".data"},  64'(out_data), (has &&  h.is_imm) ? 64'(h.data) : 64'd0);
      chk({tag, ".count"}, 64'(count),    64'(sb.size()));
      chk({tag, ".empty"}, 64'(empty),    64'(!has));
      chk({tag, ".ready"}, 64'(in_ready), 64'(sb.size() < DEPTH));
      chk({tag, ".error"}, 64'(error),    64'(m_err));
   endtask

   task automatic step(input bit mv, input bit imm, input logic [PORT_WIDTH-1:0] src,
                       input logic [PORT_WIDTH-1:0] dst, input logic [DATA_WIDTH-1:0] data,
                       input bit ordy, input string tag);
      bit     push;
      bit     pop;
      entry_t e;
      in_move_valid      = mv;
      in_immediate_valid = imm;
      in_src             = src;
      in_dst             = dst;
      in_data            = data;
      out_ready          = ordy;
      check_state(tag);
      push = (mv ^ imm) && (sb.size() < DEPTH);
      pop  = (sb.size() != 0) && ordy;
      e.is_imm = imm;
      e.src    = src;
      e.dst    = dst;
      e.data   = data;
      @(posedge clock);
      #1;
      if (mv && imm) m_err = 1'b1;
      if (pop)  void'(sb.pop_front());
      if (push) sb.push_back(e);
   endtask

   task automatic idle(input bit ordy, input string tag);
      step(1'b0, 1'b0, '0, '0, '0, ordy, tag);
   endtask

   task automatic apply_reset();
      reset              = 1'b1;
      in_move_valid      = 1'b1;
      in_immediate_valid = 1'b0;
      in_src             = 8'h11;
      in_dst             = 8'h22;
      in_data            = '0;
      out_ready          = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      sb.delete();
      m_err = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_err       = 1'b0;

      apply_reset();
      check_state("reset");

      // Single move appears one cycle after the push edge.
      step(1'b1, 1'b0, 8'd3, 8'd5, 32'hDEAD, 1'b0, "mv_push");
      idle(1'b0, "mv_show");
      idle(1'b1, "mv_pop");
      idle(1'b0, "mv_gone");

      // Fill with four immediates, offer a fifth while full, then drain.
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b1, 8'hFF, 8'(i + 1), 32'hA + 32'(i), 1'b0, "fill");
      step(1'b0, 1'b1, 8'h00, 8'h09, 32'hE, 1'b0, "full_offer");
      for (int i = 0; i < 4; i++) idle(1'b1, "drain");
      idle(1'b0, "drained");

      // Concurrent push and pop at occupancy 2, wrapping the pointers.
      step(1'b1, 1'b0, 8'h40, 8'h41, 32'h0, 1'b0, "pre0");
      step(1'b0, 1'b1, 8'h00, 8'h42, 32'h100, 1'b0, "pre1");
      for (int i = 0; i < 10; i++)
         step(i[0], !i[0], 8'(8'h50 + i), 8'(8'h60 + i), 32'h200 + 32'(i), 1'b1, "pushpop");
      idle(1'b0, "pp_done");

      // Conflicting valids set the sticky error and push nothing.
      step(1'b1, 1'b1, 8'h77, 8'h78, 32'h79, 1'b0, "conflict");
      idle(1'b0, "err_set");
      step(1'b1, 1'b0, 8'h01, 8'h02, 32'h0, 1'b1, "err_keep0");
      for (int i = 0; i < 3; i++) idle(1'b1, "err_keep");

      // Reset with three buffered entries while pushing and popping.
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 8'h0, 8'(i), 32'h300 + 32'(i), 1'b0, "pre_rst");
      apply_reset();
      check_state("post_rst");

      // Alternating types with random back-pressure.
      for (int i = 0; i < 60; i++) begin
         bit is_mv;
         bit go;
         is_mv = (i % 2 == 0);
         go    = ($urandom_range(0, 3) != 0);
         step(go && is_mv, go && !is_mv, 8'($urandom), 8'($urandom), 32'($urandom),
              1'($urandom_range(0, 1)), "rand");
      end
      for (int i = 0; i < DEPTH + 1; i++) idle(1'b1, "final_drain");
      check_state("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mib_queue.md
MIB_QUEUE -- requirements
Module: mib_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered instruction entries (power of two, >=2).
REQ-002 Parameter PORT_WIDTH, default 8, width of source/destination port fields.
REQ-003 Parameter DATA_WIDTH, default 32, width of immediate data field.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_move_valid  input  1  upstream offers a move instruction (src->dst).
REQ-007 in_immediate_valid  input  1  upstream offers an immediate instruction (data->dst).
REQ-008 in_src  input  PORT_WIDTH  move source port.
REQ-009 in_dst  input  PORT_WIDTH  destination port, both types.
REQ-010 in_data  input  DATA_WIDTH  immediate value.
REQ-011 in_ready  output  1  queue accepts an entry this cycle.
REQ-012 out_move_valid  output  1  head entry is a move.
REQ-013 out_immediate_valid  output  1  head entry is an immediate.
REQ-014 out_src, out_dst  output  PORT_WIDTH each  head fields.
REQ-015 out_data  output  DATA_WIDTH  head immediate value.
REQ-016 out_ready  input  1  downstream consumes head this cycle.
REQ-017 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-018 empty  output  1  count==0; upstream control unit uses it for drain detection.
REQ-019 error  output  1  sticky protocol-violation flag.

Function
REQ-020 Push SHALL occur when (in_move_valid XOR in_immediate_valid) && in_ready; the entry stores type bit, in_dst, and in_src (move) or in_data (immediate).
REQ-021 in_ready SHALL equal !full, with full = (count==DEPTH); no combinational path from out_ready to in_ready.
REQ-022 Pop SHALL occur when (out_move_valid || out_immediate_valid) && out_ready.
REQ-023 Head outputs SHALL be show-ahead: an entry pushed into an empty queue SHALL appear at the outputs exactly one cycle after the push edge.
REQ-024 At most one of out_move_valid/out_immediate_valid SHALL be high; both low when empty.
REQ-025 For an immediate head, out_src SHALL be 0; for a move head, out_data SHALL be 0; all data outputs SHALL be 0 when empty.
REQ-026 Output fields SHALL remain stable while a valid is high and out_ready is low.
REQ-027 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 Simultaneous push and pop: count unchanged, FIFO order preserved.
REQ-029 Push while full is impossible (in_ready low); offered instructions SHALL be ignored, not stored.
REQ-030 in_move_valid && in_immediate_valid in the same cycle SHALL push nothing and set error to 1.
REQ-031 error SHALL stay 1 until reset; the queue SHALL otherwise keep operating normally.
REQ-032 count SHALL change by +1 on push-only, -1 on pop-only, and never exceed DEPTH or go below 0.

Reset
REQ-033 On reset high at a clock edge: pointers=0, count=0, error=0, both out valids=0, data outputs=0, empty=1, in_ready=1.
REQ-034 Reset SHALL take priority over simultaneous push/pop; buffered entries SHALL be discarded.
REQ-035 Storage array contents need not be cleared by reset.

Verification
REQ-036 Push move (src=3, dst=5), out_ready=0 -> next cycle out_move_valid=1, out_src=3, out_dst=5, out_data=0, count=1, empty=0.
REQ-037 Push 4 immediates (data 0xA..0xD), out_ready=0 -> count=4, in_ready=0; 5th offered entry ignored; with out_ready=1, 0xA,0xB,0xC,0xD pop in order, then empty=1.
REQ-038 Queue at count=2, push and pop same cycle for 10 cycles -> count stays 2, pointers wrap, output order matches input order.
REQ-039 Both in valids high for one cycle -> count unchanged, error=1 and stays 1 across later normal pushes/pops.
REQ-040 Reset asserted with count=3 and push/pop active -> next cycle count=0, empty=1, error=0, both out valids 0.
REQ-041 Alternate move/immediate pushes with random out_ready -> type bit and fields match a reference model at every pop.
